// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling ratio
// and default clock/baud constants. UART_PARITY_EN adds the PARITY state.
`timescale 1ns/1ps

package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int DEF_CLK_HZ = 100_000_000;
    localparam int DEF_BAUD   = 115200;

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_HIGH
    } uart_state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_HIGH
    } uart_state_t;
`endif

    // Clocks per oversample tick, never below one.
    function automatic int baud_div(input int clk_hz, input int baud);
        int d;
        d = clk_hz / (baud * OVERSAMPLE);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Receiver-side bundle: serial line in, byte and status pulses out.
// slave = the receiver, master = line driver / byte consumer.
`timescale 1ns/1ps

interface uart_receiver_if;

    logic       rx;
    logic [7:0] rdata;
    logic       rvalid;
    logic       ferr;
    logic       perr;

    modport master (
        output rx,
        input  rdata,
        input  rvalid,
        input  ferr,
        input  perr
    );

    modport slave (
        input  rx,
        output rdata,
        output rvalid,
        output ferr,
        output perr
    );

endinterface

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick: one-clk pulse every CLK_HZ/(BAUD*16) clks.
// Ports: clk, rst (sync, active-high), tick (out).
`timescale 1ns/1ps

module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLK_HZ = DEF_CLK_HZ,
    parameter int BAUD   = DEF_BAUD
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int DIV = baud_div(CLK_HZ, BAUD);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_receiver.sv
// 16x oversampling UART receiver, 8N1 (8E1 with UART_PARITY_EN).
// Ports: clk, rst (sync, active-high), bus (slave): rx, rdata, rvalid, ferr, perr.
`timescale 1ns/1ps

module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLK_HZ = DEF_CLK_HZ,
    parameter int BAUD   = DEF_BAUD
) (
    input  logic         clk,
    input  logic         rst,
    uart_receiver_if.slave bus
);

    logic        rx_meta;
    logic        rx_s;
    logic        tick;

    uart_state_t state;
    uart_state_t state_nxt;

    logic [3:0]  os_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shreg;
    logic [7:0]  rdata_q;
    logic        rvalid_q;
    logic        ferr_q;

    logic        os_clr;
    logic        os_inc;
    logic        bit_clr;
    logic        shift_en;
    logic        load_en;
    logic        ferr_set;

`ifdef UART_PARITY_EN
    logic        par_en;
    logic        par_err;
    logic        perr_set;
    logic        perr_q;
`endif

    // Sample points: mid start bit, then every 16 ticks.
    logic mid_start;
    logic bit_end;

    assign mid_start = tick && (os_cnt == 4'd7);
    assign bit_end   = tick && (os_cnt == 4'd15);

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= bus.rx;
            rx_s    <= rx_meta;
        end
    end

    uart_baud_tick #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (tick && !rx_s) state_nxt = ST_START;
            end
            ST_START: begin
                if (mid_start) state_nxt = rx_s ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (bit_end && (bit_cnt == 3'd7)) begin
`ifdef UART_PARITY_EN
                    state_nxt = ST_PARITY;
`else
                    state_nxt = ST_STOP;
`endif
                end
            end
`ifdef UART_PARITY_EN
            ST_PARITY: begin
                if (bit_end) state_nxt = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (bit_end) state_nxt = rx_s ? ST_IDLE : ST_WAIT_HIGH;
            end
            ST_WAIT_HIGH: begin
                if (tick && rx_s) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        os_clr   = 1'b0;
        os_inc   = 1'b0;
        bit_clr  = 1'b0;
        shift_en = 1'b0;
        load_en  = 1'b0;
        ferr_set = 1'b0;
`ifdef UART_PARITY_EN
        par_en   = 1'b0;
        perr_set = 1'b0;
`endif
        unique case (state)
            ST_IDLE: begin
                if (tick && !rx_s) begin
                    os_clr  = 1'b1;
                    bit_clr = 1'b1;
                end
            end
            ST_START: begin
                if (mid_start) begin
                    os_clr  = 1'b1;
                    bit_clr = 1'b1;
                end else begin
                    os_inc = tick;
                end
            end
            ST_DATA: begin
                os_inc   = tick;
                shift_en = bit_end;
            end
`ifdef UART_PARITY_EN
            ST_PARITY: begin
                os_inc = tick;
                par_en = bit_end;
            end
`endif
            ST_STOP: begin
                os_inc = tick;
                if (bit_end) begin
                    // A low stop bit wins over a parity error.
                    if (!rx_s) ferr_set = 1'b1;
`ifdef UART_PARITY_EN
                    else if (par_err) perr_set = 1'b1;
`endif
                    else load_en = 1'b1;
                end
            end
            ST_WAIT_HIGH: begin
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            os_cnt   <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            rvalid_q <= load_en;
            ferr_q   <= ferr_set;
            if (os_clr) begin
                os_cnt <= '0;
            end else if (os_inc) begin
                os_cnt <= os_cnt + 1'b1;
            end
            if (bit_clr) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            // LSB arrives first, so shift in from the top.
            if (shift_en) shreg <= {rx_s, shreg[7:1]};
            if (load_en) rdata_q <= shreg;
        end
    end

`ifdef UART_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            par_err <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            perr_q <= perr_set;
            // Even parity: data bits plus parity bit must XOR to 0.
            if (bit_clr) begin
                par_err <= 1'b0;
            end else if (par_en) begin
                par_err <= ^{shreg, rx_s};
            end
        end
    end

    assign bus.perr = perr_q;
`else
    assign bus.perr = 1'b0;
`endif

    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
    assign bus.ferr   = ferr_q;

endmodule
